clk_gate_ctrl: RTL
==================

Name: clk_gate_ctrl

Overview:
- Per-channel clock-gate sequencer for the buffered clock tree.
- Takes clock-request lines from NUM_CH downstream consumers and drives the enable input of each consumer's clock gate.
- Enforces a wake-up settle time before acknowledging a request.
- Holds the clock for an idle hysteresis window after the request drops, so short request gaps do not toggle the gate.
- Sits directly after the clock buffer output, one instance per gated region.

Parameters:
NUM_CH, 4, number of independent gated channels (1..16)
WAKE_CYCLES, 2, cycles from gate_en rising to ack rising (>=1)
IDLE_CYCLES, 8, cycles gate_en stays high after leaving ON with no request (>=1)
CNT_W, 4, counter width; must hold max(WAKE_CYCLES, IDLE_CYCLES)-1

Ports:
clk_in  input  1  buffered clock; all logic rising-edge
rst  input  1  asynchronous, active-high reset
req  input  NUM_CH  per-channel clock request; synchronous to clk_in, level
force_on  input  1  test/debug override; forces all gate_en high
gate_en  output  NUM_CH  registered enable to each channel's clock gate
ack  output  NUM_CH  registered; clock is stable and granted for that channel
busy  output  1  OR of gate_en (combinational from registered gate_en)

Behaviour:
- One clock (clk_in); reset is asynchronous and active-high (rst).
- Reset:
  - On rst assertion, every channel enters OFF immediately, without waiting for a clock edge.
  - gate_en=0, ack=0, busy=0 while rst is high; all counters = 0.
  - Reset mid-operation (any state) behaves identically.
  - First state change is on the first clk_in edge after rst deasserts.
- Channels are independent; each channel has its own FSM {OFF, WAKE, ON, IDLE} and its own CNT_W counter.
- Outputs are Moore-decoded and registered:
  - OFF: gate_en=0, ack=0
  - WAKE: gate_en=1, ack=0
  - ON: gate_en=1, ack=1
  - IDLE: gate_en=1, ack=0
- OFF:
  - req=1 sampled -> WAKE, cnt=WAKE_CYCLES-1.
  - gate_en rises on the same edge.
- WAKE:
  - cnt!=0: decrement.
  - cnt==0: -> ON; ack rises exactly WAKE_CYCLES cycles after gate_en.
  - WAKE always completes; req dropping during WAKE is ignored until ON is reached.
- ON:
  - req=1: stay.
  - req=0 sampled: -> IDLE, cnt=IDLE_CYCLES-1; ack falls on that edge.
- IDLE:
  - req=1: -> ON; ack rises on the next edge, with no wake delay because the clock never stopped.
  - req=0 and cnt!=0: decrement.
  - req=0 and cnt==0: -> OFF; gate_en falls exactly IDLE_CYCLES cycles after entering IDLE.
- Simultaneous events:
  - In IDLE with cnt==0 and req=1 on the same edge, req wins -> ON.
- force_on:
  - gate_en output = state-decoded enable OR force_on, registered, so it takes effect 1 cycle after force_on.
  - The FSM and ack behaviour are unaffected by force_on.
  - A channel that is OFF while force_on=1 still goes through WAKE on req.
- busy = |gate_en.
- Counters never wrap: they are only loaded on state entry and only decremented while nonzero.
- Elaboration checks: WAKE_CYCLES>=1; IDLE_CYCLES>=1; CNT_W sufficient. Violation is an elaboration error.

Decomposition:
- Shared package clk_gate_pkg holds:
  - the state enum type chan_state_t {OFF, WAKE, ON, IDLE}
  - a localparam function computing the minimum CNT_W
- One sub-module clk_gate_chan: single-channel FSM, counter and output registers.
- clk_gate_ctrl generates NUM_CH instances and adds the force_on OR and the busy reduction.

Test Plan:
1. Reset:
   - Assert rst mid-ON on channel 0 between edges.
   - Required: gate_en[0] and ack[0] drop to 0 before the next edge.
   - After release with req=0: outputs stay 0.
2. Wake latency (defaults):
   - req[1] 0->1 sampled at edge N.
   - Required: gate_en[1]=1 after edge N; ack[1]=1 after edge N+2; other channels stay 0.
3. Idle hysteresis:
   - Channel 2 in ON; req[2] drops, sampled at edge M.
   - Required: ack[2]=0 after edge M; gate_en[2]=1 through edge M+7; gate_en[2]=0 after edge M+8.
4. Re-request in IDLE:
   - Drop req[3] for 3 cycles, then reassert.
   - Required: ack[3] returns 1 one edge after reassert sample; gate_en[3] never deasserts.
   - Also cover the boundary: reassert exactly on the cnt==0 edge -> ON, not OFF.
5. Short pulse:
   - 1-cycle req[0] pulse from OFF.
   - Required: WAKE completes (ack[0]=1 for exactly 1 cycle at N+2), then IDLE for 8 cycles, then OFF.
   - Total gate_en high time = 2+1+8 = 11 cycles.
6. force_on with all req=0:
   - Required: gate_en=4'b1111 one cycle later; ack=0; busy=1.
   - Deassert force_on: gate_en=0 one cycle later.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared types and elaboration helpers for the per-channel clock-gate sequencer.
// Holds the channel state encoding and the minimum counter-width calculation.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        IDLE = 2'd3
    } chan_state_t;

    // Smallest width able to hold the largest counter load, max(WAKE, IDLE) - 1.
    function automatic int min_cnt_w(input int wake_cycles, input int idle_cycles);
        int max_load;
        int w;
        max_load = ((wake_cycles > idle_cycles) ? wake_cycles : idle_cycles) - 1;
        w = 1;
        while ((1 << w) <= max_load) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Request/grant bundle between the gated consumers and the clock-gate sequencer.
// master = consumer side raising requests, slave = the sequencer.
interface clk_gate_ctrl_if #(
    parameter int NUM_CH = 4
);

    logic [NUM_CH-1:0] req;
    logic              force_on;
    logic [NUM_CH-1:0] gate_en;
    logic [NUM_CH-1:0] ack;
    logic              busy;

    modport master (
        output req,
        output force_on,
        input  gate_en,
        input  ack,
        input  busy
    );

    modport slave (
        input  req,
        input  force_on,
        output gate_en,
        output ack,
        output busy
    );

endinterface

// File: rtl/clk_gate_chan.sv
// Single-channel clock-gate FSM: OFF -> WAKE (settle) -> ON -> IDLE (hysteresis) -> OFF.
// Enable and ack are decoded from the next state so they are registered Moore outputs.
module clk_gate_chan
    import clk_gate_pkg::*;
#(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic clk_in,
    input  logic rst,
    input  logic req,
    output logic en,
    output logic ack
);

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    chan_state_t      state_q;
    chan_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             en_q;
    logic             en_d;
    logic             ack_q;
    logic             ack_d;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= OFF;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
        end
    end

    // Counter is loaded only on state entry and decremented only while nonzero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            OFF: begin
                if (req) begin
                    state_d = WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            WAKE: begin
                // The settle window always runs to completion, whatever req does.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ON;
                end
            end
            ON: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = IDLE_LOAD;
                end
            end
            IDLE: begin
                // A request wins over expiry: the clock is still running, so no re-wake.
                if (req) begin
                    state_d = ON;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = OFF;
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        en_d  = (state_d != OFF);
        ack_d = (state_d == ON);
    end

    assign en  = en_q;
    assign ack = ack_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate sequencer for one gated region: NUM_CH independent channel FSMs,
// a registered global force-on override and the region busy indication.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input logic           clk_in,
    input logic           rst,
    clk_gate_ctrl_if.slave bus
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_chk_num_ch
        $error("clk_gate_ctrl: NUM_CH must be in 1..16");
    end
    if (WAKE_CYCLES < 1) begin : g_chk_wake
        $error("clk_gate_ctrl: WAKE_CYCLES must be >= 1");
    end
    if (IDLE_CYCLES < 1) begin : g_chk_idle
        $error("clk_gate_ctrl: IDLE_CYCLES must be >= 1");
    end
    if (CNT_W < min_cnt_w(WAKE_CYCLES, IDLE_CYCLES)) begin : g_chk_cnt_w
        $error("clk_gate_ctrl: CNT_W too narrow for WAKE_CYCLES/IDLE_CYCLES");
    end

    logic [NUM_CH-1:0] en_vec;
    logic [NUM_CH-1:0] ack_vec;
    logic              force_q;
    logic              force_d;
    logic [NUM_CH-1:0] gate_en;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clk_gate_chan #(
            .WAKE_CYCLES (WAKE_CYCLES),
            .IDLE_CYCLES (IDLE_CYCLES),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk_in (clk_in),
            .rst    (rst),
            .req    (bus.req[i]),
            .en     (en_vec[i]),
            .ack    (ack_vec[i])
        );
    end

    // Registering force_on separately and ORing after the channel flops equals
    // registering (decoded enable | force_on); the FSMs never see the override.
    always_comb begin
        force_d = bus.force_on;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            force_q <= 1'b0;
        end else begin
            force_q <= force_d;
        end
    end

    assign gate_en     = en_vec | {NUM_CH{force_q}};
    assign bus.gate_en = gate_en;
    assign bus.ack     = ack_vec;
    assign bus.busy    = |gate_en;

endmodule
